// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline RAM port between I-cache and D-cache.
// One grant at a time, with an idle bubble between grants.
module cache_arbiter #(
    parameter int s_addr = 32,
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [s_addr-1:0] i_addr,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_addr,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              ram_read,
    output logic              ram_write,
    output logic [s_addr-1:0] ram_addr,
    output logic [s_line-1:0] ram_wdata,
    input  logic [s_line-1:0] ram_rdata,
    input  logic              ram_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t state, state_next;
    logic   last, last_next;
    logic   d_req;

    assign d_req     = d_read | d_write;
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;
    assign ram_wdata = d_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= LAST_D;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        ram_addr   = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_read && (!d_req || last == LAST_D)) begin
                    state_next = SERVE_I;
                    last_next  = LAST_I;
                end else if (d_req) begin
                    state_next = SERVE_D;
                    last_next  = LAST_D;
                end
            end
            SERVE_I: begin
                // A dropped request abandons the grant without a response
                if (!i_read) begin
                    state_next = IDLE;
                end else begin
                    ram_read = 1'b1;
                    ram_addr = i_addr;
                    i_resp   = ram_resp;
                    if (ram_resp) state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (!d_req) begin
                    state_next = IDLE;
                end else begin
                    ram_write = d_write;
                    ram_read  = d_read & ~d_write;
                    ram_addr  = d_addr;
                    d_resp    = ram_resp;
                    if (ram_resp) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Table-driven bench for cache_arbiter: one vector per clock cycle,
// expected outputs queued at drive time and compared before the next edge.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          ram_read;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [LW-1:0] ram_wdata;
    logic [LW-1:0] ram_rdata = '0;
    logic          ram_resp = 1'b0;

    cache_arbiter #(.s_addr(AW), .s_line(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .ram_read (ram_read),
        .ram_write(ram_write),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_resp (ram_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         grp;
        logic          rst;
        logic          ir;
        logic          dr;
        logic          dw;
        logic          rr;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic          e_ir;
        logic          e_dr;
    } vec_t;

    vec_t  vecs[$];
    vec_t  exp_q[$];
    string grp;
    int    tests = 0;
    int    fails = 0;

    function automatic void add(
        input logic rs, input logic ir, input logic dr,
        input logic dw, input logic rr,
        input logic [AW-1:0] ia, input logic [AW-1:0] da,
        input logic erd, input logic ewr, input logic [AW-1:0] ea,
        input logic eir, input logic edr);
        vec_t v;
        v.grp = grp; v.rst = rs; v.ir = ir; v.dr = dr; v.dw = dw;
        v.rr = rr; v.ia = ia; v.da = da; v.e_rd = erd; v.e_wr = ewr;
        v.e_addr = ea; v.e_ir = eir; v.e_dr = edr;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic ir, input logic dr,
                                 input logic dw, input logic rr,
                                 input logic [AW-1:0] ia,
                                 input logic [AW-1:0] da);
        add(1, ir, dr, dw, rr, ia, da, 0, 0, 0, 0, 0);
    endfunction

    function automatic void rst_vec();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input int k, input logic [LW-1:0] rd,
                         input logic [LW-1:0] wd);
        vec_t e;
        e = exp_q.pop_front();
        tests++;
        if ({ram_read, ram_write, ram_addr, i_resp, d_resp} !==
            {e.e_rd, e.e_wr, e.e_addr, e.e_ir, e.e_dr}) begin
            fails++;
            $display("FAIL %s vec%0d: got rd=%b wr=%b addr=%h ir=%b dr=%b, want rd=%b wr=%b addr=%h ir=%b dr=%b",
                     e.grp, k, ram_read, ram_write, ram_addr, i_resp, d_resp,
                     e.e_rd, e.e_wr, e.e_addr, e.e_ir, e.e_dr);
        end
        if (e.e_ir) begin
            tests++;
            if (i_rdata !== rd) begin
                fails++;
                $display("FAIL %s vec%0d i_rdata: got %h want %h", e.grp, k, i_rdata, rd);
            end
        end
        if (e.e_dr) begin
            tests++;
            if (d_rdata !== rd) begin
                fails++;
                $display("FAIL %s vec%0d d_rdata: got %h want %h", e.grp, k, d_rdata, rd);
            end
        end
        if (e.e_wr) begin
            tests++;
            if (ram_wdata !== wd) begin
                fails++;
                $display("FAIL %s vec%0d ram_wdata: got %h want %h", e.grp, k, ram_wdata, wd);
            end
        end
    endtask

    initial begin
        logic [LW-1:0] rd;
        logic [LW-1:0] wd;

        grp = "reset";
        rst_vec(); rst_vec();

        grp = "single_i";
        idle(1, 0, 0, 0, 'h40, 0);
        add(1, 1, 0, 0, 0, 'h40, 0, 1, 0, 'h40, 0, 0);
        add(1, 1, 0, 0, 0, 'h40, 0, 1, 0, 'h40, 0, 0);
        add(1, 1, 0, 0, 0, 'h40, 0, 1, 0, 'h40, 0, 0);
        add(1, 1, 0, 0, 1, 'h40, 0, 1, 0, 'h40, 1, 0);
        idle(0, 0, 0, 0, 0, 0);

        grp = "tie_first";
        rst_vec();
        idle(1, 1, 0, 0, 'h100, 'h200);
        add(1, 1, 1, 0, 1, 'h100, 'h200, 1, 0, 'h100, 1, 0);
        idle(0, 1, 0, 0, 'h100, 'h200);
        add(1, 0, 1, 0, 1, 'h100, 'h200, 1, 0, 'h200, 0, 1);
        idle(0, 0, 0, 0, 0, 0);

        grp = "round_robin";
        rst_vec();
        for (int t = 0; t < 2; t++) begin
            idle(1, 1, 0, 0, 'h100, 'h200);
            add(1, 1, 1, 0, 1, 'h100, 'h200, 1, 0, 'h100, 1, 0);
            idle(1, 1, 0, 0, 'h100, 'h200);
            add(1, 1, 1, 0, 1, 'h100, 'h200, 1, 0, 'h200, 0, 1);
        end
        idle(0, 0, 0, 0, 0, 0);

        grp = "wb_then_fetch";
        rst_vec();
        idle(0, 0, 1, 0, 0, 'h1000);
        add(1, 0, 0, 1, 0, 0, 'h1000, 0, 1, 'h1000, 0, 0);
        add(1, 0, 0, 1, 1, 0, 'h1000, 0, 1, 'h1000, 0, 1);
        idle(1, 1, 0, 0, 'h40, 'h2000);
        add(1, 1, 1, 0, 1, 'h40, 'h2000, 1, 0, 'h40, 1, 0);
        idle(0, 1, 0, 0, 'h40, 'h2000);
        add(1, 0, 1, 0, 1, 'h40, 'h2000, 1, 0, 'h2000, 0, 1);
        idle(0, 0, 0, 0, 0, 0);

        grp = "stray_and_rw";
        rst_vec();
        idle(0, 0, 0, 1, 0, 0);
        idle(0, 1, 1, 0, 0, 'h300);
        add(1, 0, 1, 1, 1, 0, 'h300, 0, 1, 'h300, 0, 1);
        idle(0, 0, 0, 0, 0, 0);

        grp = "abort";
        idle(1, 0, 0, 0, 'h40, 0);
        add(1, 1, 0, 0, 0, 'h40, 0, 1, 0, 'h40, 0, 0);
        idle(0, 0, 0, 1, 'h40, 0);
        idle(0, 1, 0, 0, 0, 'h200);
        add(1, 0, 1, 0, 1, 0, 'h200, 1, 0, 'h200, 0, 1);
        idle(0, 0, 0, 0, 0, 0);

        grp = "reset_mid";
        rst_vec();
        idle(0, 0, 1, 0, 0, 'h1000);
        add(1, 0, 0, 1, 0, 0, 'h1000, 0, 1, 'h1000, 0, 0);
        add(0, 0, 0, 1, 1, 0, 'h1000, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 'h100, 'h200, 0, 0, 0, 0, 0);
        idle(1, 1, 0, 0, 'h100, 'h200);
        add(1, 1, 1, 0, 1, 'h100, 'h200, 1, 0, 'h100, 1, 0);
        idle(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rd = {8{32'hA5A5_0000 | 32'(k)}};
            wd = {8{32'hDEAD_0000 | 32'(k)}};
            rst       = vecs[k].rst;
            i_read    = vecs[k].ir;
            d_read    = vecs[k].dr;
            d_write   = vecs[k].dw;
            ram_resp  = vecs[k].rr;
            i_addr    = vecs[k].ia;
            d_addr    = vecs[k].da;
            ram_rdata = rd;
            d_wdata   = wd;
            exp_q.push_back(vecs[k]);
            #1;
            check(k, rd, wd);
        end

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: %0d left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
